// File: rtl/ir_report_decoder.sv
// IR camera extended-mode report decoder: collects one report byte per strobe, decodes the four
// blob slots and tracks one of them, flagging loss of track after a run of empty reports.
module ir_report_decoder #(
    parameter int unsigned REPORT_BYTES = 16,
    parameter int unsigned TRACK_BLOB   = 0,
    parameter int unsigned LOST_FRAMES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [3:0] size,
    output logic [3:0] blob_mask,
    output logic       pos_valid,
    output logic       frame_done,
    output logic       lost
);
    localparam int unsigned CntW     = $clog2(REPORT_BYTES);
    localparam int unsigned NumBlobs = 4;
    localparam int unsigned BufBytes = NumBlobs * 3;
    localparam logic [1:0]  TrackIdx = 2'(TRACK_BLOB);
    localparam logic [7:0]  MissMax  = 8'(LOST_FRAMES);

    typedef enum logic [1:0] {StIdle, StCollect, StDecode} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   wr_idx;
    logic              buf_we;
    logic [7:0]        buf_q [BufBytes];
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [3:0]        size_q, size_d, mask_q, mask_d;
    logic              pos_valid_q, pos_valid_d, frame_done_q, frame_done_d, lost_q, lost_d;
    logic [7:0]        miss_q, miss_d;

    logic [NumBlobs-1:0] blob_valid;
    logic [9:0]          dec_x [NumBlobs];
    logic [9:0]          dec_y [NumBlobs];
    logic [3:0]          dec_s [NumBlobs];

    for (genvar n = 0; n < NumBlobs; n++) begin : g_blob
        assign blob_valid[n] = ~((buf_q[3*n] == 8'hFF) && (buf_q[3*n+1] == 8'hFF)
                                 && (buf_q[3*n+2] == 8'hFF));
        assign dec_x[n] = {buf_q[3*n+2][5:4], buf_q[3*n]};
        assign dec_y[n] = {buf_q[3*n+2][7:6], buf_q[3*n+1]};
        assign dec_s[n] = buf_q[3*n+2][3:0];
    end

    assign wr_idx = cnt_q - CntW'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_we       = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        size_d       = size_q;
        mask_d       = mask_q;
        pos_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        miss_d       = miss_q;
        lost_d       = lost_q;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d = StCollect;
                    cnt_d   = '0;
                end
            end
            StCollect: begin
                if (frame_start) begin
                    cnt_d = '0;
                end else if (byte_valid) begin
                    // Header and trailing bytes are counted but never stored.
                    buf_we = (cnt_q >= CntW'(1)) && (cnt_q <= CntW'(BufBytes));
                    if (cnt_q == CntW'(REPORT_BYTES - 1)) begin
                        state_d = StDecode;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StDecode: begin
                frame_done_d = 1'b1;
                mask_d       = blob_valid;
                if (blob_valid[TrackIdx]) begin
                    x_d         = dec_x[TrackIdx];
                    y_d         = dec_y[TrackIdx];
                    size_d      = dec_s[TrackIdx];
                    pos_valid_d = 1'b1;
                    miss_d      = '0;
                    lost_d      = 1'b0;
                end else begin
                    if (miss_q < MissMax) miss_d = miss_q + 8'd1;
                    lost_d = (miss_d == MissMax);
                end
                state_d = frame_start ? StCollect : StIdle;
                cnt_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            size_q       <= '0;
            mask_q       <= '0;
            pos_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            miss_q       <= MissMax;
            lost_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            size_q       <= size_d;
            mask_q       <= mask_d;
            pos_valid_q  <= pos_valid_d;
            frame_done_q <= frame_done_d;
            miss_q       <= miss_d;
            lost_q       <= lost_d;
        end
    end

    // Buffer needs no reset: a decode only happens after all of it has been rewritten.
    always_ff @(posedge clk) begin
        if (reset && buf_we) buf_q[wr_idx] <= byte_in;
    end

    assign x          = x_q;
    assign y          = y_q;
    assign size       = size_q;
    assign blob_mask  = mask_q;
    assign pos_valid  = pos_valid_q;
    assign frame_done = frame_done_q;
    assign lost       = lost_q;
endmodule
